pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_pkg.sv | 16 +
 rtl/pulse_train_gen.sv | 125 ++++++++++++
 tb/tb_pulse_train_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse train generator and the pulse_delay stage
// that consumes its output.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // pulse_delay sizing: delay line depth counter width and typical delay.
  localparam int DELAY_W           = 8;
  localparam int DELAY_NUM_DEFAULT = 5;

endpackage

// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: width-cycle high pulses every period
// cycles, for pulse_num pulses (0 = until stop). All outputs are registered.
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] pulse_num,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] pulse_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic [CNT_W-1:0] w_pulse_cnt_nxt;
  logic             r_pulse_out;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_err;
  logic             w_pulse_out_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_cfg_err_nxt;
  logic             w_cfg_ok;
  logic             w_start_req;
  logic             w_accept;
  logic             w_reject;
  logic             w_phase_last;
  logic             w_more;

  // stop masks start in IDLE, so it suppresses both a train and cfg_err.
  assign w_cfg_ok     = (period >= CNT_W'(2)) && (width != '0) && (width < period);
  assign w_start_req  = (r_state == IDLE) && start && !stop;
  assign w_accept     = w_start_req && w_cfg_ok;
  assign w_reject     = w_start_req && !w_cfg_ok;
  assign w_phase_last = (r_phase <= CNT_W'(1));
  assign w_more       = (r_num == '0) || (r_pulse_cnt < r_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_period    <= '0;
      r_width     <= '0;
      r_num       <= '0;
      r_phase     <= '0;
      r_pulse_cnt <= '0;
      r_pulse_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_pulse_out <= w_pulse_out_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_cfg_err   <= w_cfg_err_nxt;
      if (w_accept) begin
        r_period <= period;
        r_width  <= width;
        r_num    <= pulse_num;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = HIGH;
      HIGH: begin
        if (stop)              w_state_nxt = DONE;
        else if (w_phase_last) w_state_nxt = LOW;
      end
      LOW: begin
        if (stop)              w_state_nxt = DONE;
        else if (w_phase_last) w_state_nxt = w_more ? HIGH : DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // One phase counter serves both HIGH and LOW; it is reloaded on every
  // phase entry and otherwise counts down, holding at zero.
  always_comb begin
    w_phase_nxt     = (r_phase == '0) ? r_phase : r_phase - CNT_W'(1);
    w_pulse_cnt_nxt = r_pulse_cnt;
    if (w_accept) begin
      w_phase_nxt     = width;
      w_pulse_cnt_nxt = CNT_W'(1);
    end else if (r_state == HIGH && w_state_nxt == LOW) begin
      w_phase_nxt = r_period - r_width;
    end else if (r_state == LOW && w_state_nxt == HIGH) begin
      w_phase_nxt = r_width;
      if (r_pulse_cnt != '1) w_pulse_cnt_nxt = r_pulse_cnt + CNT_W'(1);
    end
    w_pulse_out_nxt = (w_state_nxt == HIGH);
    w_busy_nxt      = (w_state_nxt == HIGH) || (w_state_nxt == LOW);
    w_done_nxt      = (w_state_nxt == DONE);
    w_cfg_err_nxt   = w_reject;
  end

  assign pulse_out = r_pulse_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;
  assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen; expected waveforms are
// hand-derived, with k counting cycles after the edge that accepted start.
module tb_pulse_train_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [31:0] period;
  logic [31:0] width;
  logic [31:0] pulse_num;
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [31:0] pulse_cnt;

  int nChecks;
  int nBad;

  pulse_train_gen #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .period    (period),
    .width     (width),
    .pulse_num (pulse_num),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .pulse_cnt (pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the next negedge with start/stop dropped.
  task automatic applyStimulus(input int p, input int w, input int n, input logic s);
    period    = p;
    width     = w;
    pulse_num = n;
    start     = 1'b1;
    stop      = s;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  int cfgP [3] = '{5, 5, 1};
  int cfgW [3] = '{5, 0, 1};

  initial begin
    nChecks   = 0;
    nBad      = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    period    = 0;
    width     = 0;
    pulse_num = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_pulse", pulse_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_cnt", pulse_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four 10-cycle periods with 3-cycle pulses; a start at k=15 must be ignored.
    applyStimulus(10, 3, 4, 1'b0);
    for (int k = 0; k < 42; k++) begin
      checkOutput("s1_pulse", pulse_out, (k < 40) && (k % 10 < 3));
      checkOutput("s1_busy", busy, k < 40);
      checkOutput("s1_done", done, k == 40);
      checkOutput("s1_cfg_err", cfg_err, 0);
      if (k % 10 == 0 || k == 41) checkOutput("s1_cnt", pulse_cnt, (k >= 40) ? 4 : k / 10 + 1);
      if (k == 15) begin
        start  = 1'b1;
        period = 3;
        width  = 1;
      end
      @(negedge clk);
      start = 1'b0;
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(cfgP[i], cfgW[i], 0, 1'b0);
      checkOutput("s2_cfg_err", cfg_err, 1);
      checkOutput("s2_busy", busy, 0);
      checkOutput("s2_pulse", pulse_out, 0);
      checkOutput("s2_cnt_hold", pulse_cnt, 4);
      @(negedge clk);
      checkOutput("s2_cfg_err_clr", cfg_err, 0);
      checkOutput("s2_busy_after", busy, 0);
    end

    // Continuous mode, stop raised during the third pulse's LOW phase.
    applyStimulus(4, 1, 0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      checkOutput("s3_pulse", pulse_out, (k < 10) && (k % 4 == 0));
      checkOutput("s3_busy", busy, k < 10);
      checkOutput("s3_done", done, k == 10);
      if (k == 4) checkOutput("s3_cnt2", pulse_cnt, 2);
      if (k >= 10) checkOutput("s3_cnt3", pulse_cnt, 3);
      if (k == 9) stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end

    applyStimulus(10, 3, 2, 1'b1);
    checkOutput("s4_busy", busy, 0);
    checkOutput("s4_pulse", pulse_out, 0);
    checkOutput("s4_done", done, 0);
    checkOutput("s4_cfg_err", cfg_err, 0);
    checkOutput("s4_cnt_hold", pulse_cnt, 3);
    applyStimulus(5, 5, 0, 1'b1);
    checkOutput("s4_bad_cfg_err", cfg_err, 0);
    checkOutput("s4_bad_busy", busy, 0);

    // Tightest legal config: width = period - 1, single pulse.
    applyStimulus(2, 1, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("s5_pulse", pulse_out, k == 0);
      checkOutput("s5_busy", busy, k < 2);
      checkOutput("s5_done", done, k == 2);
      checkOutput("s5_cnt", pulse_cnt, 1);
      @(negedge clk);
    end

    applyStimulus(10, 5, 0, 1'b0);
    @(negedge clk);
    checkOutput("s6_pulse_pre", pulse_out, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_async_pulse", pulse_out, 0);
    checkOutput("s6_async_busy", busy, 0);
    checkOutput("s6_async_cnt", pulse_cnt, 0);
    @(negedge clk);
    checkOutput("s6_no_done", done, 0);
    rst_n = 1'b1;
    applyStimulus(3, 1, 2, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("s6_pulse", pulse_out, (k == 0) || (k == 3));
      checkOutput("s6_busy", busy, k < 6);
      checkOutput("s6_done", done, k == 6);
      if (k == 0) checkOutput("s6_cnt1", pulse_cnt, 1);
      if (k >= 3) checkOutput("s6_cnt2", pulse_cnt, 2);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
